mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port 256x16 synchronous-read RAM between the CPU (port 0) and a memory loader/debug master (port 1). It accepts one request at a time, picks the winner round-robin, sequences the RAM command and address, and returns read data with a valid strobe. It sits between the CPU's memory interface and the RAM, replacing the CPU's direct drive of `mem_cmd`/`mem_addr`.

## Interface
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 16, RAM word width
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `m0_req`, `m1_req`  in  1  request; held with its payload until the matching `gnt`
- `m0_write`, `m1_write`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_W  word address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse: request accepted, payload consumed
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse: `rdata` valid for this port
- `rdata`  out  DATA_W  read data, shared by both ports; qualify with `rvalid`
- `mem_cmd`  out  2  RAM command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE
- `mem_addr`  out  ADDR_W  RAM address
- `mem_din`  out  DATA_W  RAM write data
- `mem_dout`  in  DATA_W  RAM read data, valid one cycle after a READ cycle

## Operation
- FSM has three states: IDLE, ACC, RESP.
- IDLE: `mem_cmd` = NONE. If any `req` is high, select the winner, latch its write, addr and wdata into internal registers and the port id into `cur`, then go to ACC. With no request, stay in IDLE.
- Winner rule: if only one port requests, that port wins. If both request, the port not equal to `last` wins. After the selection, `last` <= winner.
- ACC: drive `mem_cmd` = WRITE or READ, with `mem_addr` and `mem_din` from the latched registers. Pulse `gnt` for port `cur`. After a write, go to IDLE. After a read, go to RESP.
- RESP: `rdata` = `mem_dout`. Pulse `rvalid` for port `cur`. `mem_cmd` = NONE. Go to IDLE.
- `rdata` holds `mem_dout` in every state. Only `rvalid` qualifies it.
- A requester deasserts `req` in the cycle after its `gnt`, or keeps it high to issue another request. A `req` still high in the following IDLE cycle is a new request.
- `mem_din` and `mem_addr` hold their latched values outside ACC. Only `mem_cmd` gates the RAM.
- Requests that change payload before `gnt` are a protocol violation. The arbiter samples the payload only in IDLE.

## Timing
- Reset values:
  - state = IDLE; `last` = 1, so port 0 wins the first tie.
  - `cur` = 0.
  - all `gnt` and `rvalid` = 0; `mem_cmd` = NONE; `mem_addr` = 0; `mem_din` = 0.
- Write latency: the request is sampled in IDLE at edge N. ACC (RAM write, `gnt`) runs in cycle N+1. The arbiter is back in IDLE at N+2. Throughput is 1 write per 2 cycles.
- Read latency: sampled at edge N; ACC/`gnt` in cycle N+1; RESP/`rvalid` in cycle N+2; IDLE at N+3. Throughput is 1 read per 3 cycles.
- Worst-case wait for a port holding `req`: one 3-cycle read by the other port, then its own service. There is no starvation under continuous contention, because ports alternate.
- All outputs are Moore (decoded from state and registers). No combinational path runs from `req` to `gnt`.
- Reset mid-operation: return to IDLE in the next cycle. An in-flight read produces no `rvalid`. A write in its ACC cycle, when reset is asserted, still reaches the RAM in that cycle.
- Simultaneous requests in IDLE: exactly one `gnt` results; the loser stays pending and is served next.

## Test plan
- Reset, then port 0 writes addr 8'h19 data 16'hFFE9 (-23) -> `m0_gnt` in the cycle after the request; RAM word 25 = 16'hFFE9; `mem_cmd` returns to NONE.
- Port 1 reads addr 8'h19 after that write -> `m1_gnt` at +1, `m1_rvalid` at +2 with `rdata` = 16'hFFE9; `m0_rvalid` stays 0.
- Both ports request reads continuously from reset (addr 0 and addr 1) -> grants alternate 0,1,0,1; each port is served every 6 cycles; each `rdata` matches its own address.
- Port 0 holds `req` for 4 back-to-back writes to addrs 0..3 while port 1 is idle -> 4 `gnt` pulses spaced 2 cycles apart; RAM holds all 4 words.
- Assert `reset` during RESP of a port-1 read -> no `m1_rvalid`; FSM in IDLE; next tie grants port 0.
- Single-port requests with no contention never see `gnt` on the wrong port; `gnt` and `rvalid` never fire in the same cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundle of every signal between the two requesters, the arbiter and the
// single-port RAM.
//
//   Requester side (per port p = 0/1):
//     mp_req      request, held with its payload until mp_gnt
//     mp_write    1 = write, 0 = read
//     mp_addr     word address
//     mp_wdata    write data
//     mp_gnt      one-cycle pulse: payload consumed
//     mp_rvalid   one-cycle pulse: rdata belongs to this port
//     rdata       shared read data, qualified by mp_rvalid
//   RAM side:
//     mem_cmd     2'b00 NONE, 2'b01 READ, 2'b10 WRITE
//     mem_addr    RAM address
//     mem_din     RAM write data
//     mem_dout    RAM read data, valid the cycle after a READ
//
// Modports:
//   slave  - the arbiter
//   master - the environment: both requesters plus the RAM
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic              m0_req;
    logic              m1_req;
    logic              m0_write;
    logic              m1_write;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_gnt;
    logic              m1_gnt;
    logic              m0_rvalid;
    logic              m1_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  m0_req, m1_req, m0_write, m1_write,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  mem_dout,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
        output mem_cmd, mem_addr, mem_din
    );

    modport master (
        output m0_req, m1_req, m0_write, m1_write,
        output m0_addr, m1_addr, m0_wdata, m1_wdata,
        output mem_dout,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
        input  mem_cmd, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous-read RAM between the CPU (port 0) and a
// loader/debug master (port 1). One request is in flight at a time; ties are
// broken round-robin. Writes take two cycles (IDLE, ACC), reads three
// (IDLE, ACC, RESP).
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    mem_arbiter_if.slave - requester handshakes and RAM command bus
//
// All outputs are decoded from registered state, so there is no
// combinational path from any req to any gnt. The only exception to pure
// state decoding is rvalid, which is suppressed while reset is high so an
// interrupted read never reports data.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // RAM command encoding
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic              cur_q,   cur_d;     // port being served
    logic              last_q,  last_d;    // most recent winner
    logic              write_q, write_d;   // latched direction
    logic [ADDR_W-1:0] addr_q,  addr_d;    // latched address
    logic [DATA_W-1:0] din_q,   din_d;     // latched write data

    // -------------------------------------------------------------------------
    // Requester inputs gathered into port-indexed arrays
    // -------------------------------------------------------------------------
    logic [1:0]        req_w;
    logic [1:0]        wr_w;
    logic [ADDR_W-1:0] addr_w  [2];
    logic [DATA_W-1:0] wdata_w [2];
    logic              win_w;
    logic [1:0]        gnt_w;
    logic [1:0]        rvalid_w;

    assign req_w      = {bus.m1_req,   bus.m0_req};
    assign wr_w       = {bus.m1_write, bus.m0_write};
    assign addr_w[0]  = bus.m0_addr;
    assign addr_w[1]  = bus.m1_addr;
    assign wdata_w[0] = bus.m0_wdata;
    assign wdata_w[1] = bus.m1_wdata;

    // -------------------------------------------------------------------------
    // Winner selection. A lone requester wins outright; on a tie the port
    // that did not win last time goes, which makes contending ports alternate.
    // The 2'b00 case is never consumed (IDLE only latches when a req is up).
    // -------------------------------------------------------------------------
    always_comb begin
        win_w = 1'b0;
        case (req_w)
            2'b01:   win_w = 1'b0;
            2'b10:   win_w = 1'b1;
            2'b11:   win_w = ~last_q;
            default: win_w = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            ST_IDLE: begin
                // Payload is sampled only here; it is held in registers for
                // the rest of the transaction and beyond.
                if (|req_w) begin
                    state_d = ST_ACC;
                    cur_d   = win_w;
                    last_d  = win_w;
                    write_d = wr_w[win_w];
                    addr_d  = addr_w[win_w];
                    din_d   = wdata_w[win_w];
                end
            end
            ST_ACC: begin
                state_d = write_q ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= 1'b0;
            last_q  <= 1'b1;          // port 0 wins the first tie
            write_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-port handshake decode
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_w[gi]    = (state_q == ST_ACC)  && (cur_q == 1'(gi));
            // A read interrupted by reset must not report data, even in the
            // RESP cycle itself.
            assign rvalid_w[gi] = (state_q == ST_RESP) && (cur_q == 1'(gi)) && !reset;
        end
    endgenerate

    assign bus.m0_gnt    = gnt_w[0];
    assign bus.m1_gnt    = gnt_w[1];
    assign bus.m0_rvalid = rvalid_w[0];
    assign bus.m1_rvalid = rvalid_w[1];

    // -------------------------------------------------------------------------
    // RAM side. mem_cmd alone gates the RAM; address and data simply hold the
    // last latched payload. A write in ACC still reaches the RAM if reset is
    // raised during that cycle, because mem_cmd is decoded from state only.
    // -------------------------------------------------------------------------
    assign bus.mem_cmd  = (state_q == ST_ACC) ? (write_q ? CMD_WRITE : CMD_READ) : CMD_NONE;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;

    // Read data is passed straight through; rvalid is its only qualifier.
    assign bus.rdata    = bus.mem_dout;

    // -------------------------------------------------------------------------
    // Structural properties
    // -------------------------------------------------------------------------
    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
        !(gnt_w[0] && gnt_w[1]));
    a_gnt_rvalid_excl: assert property (@(posedge clk) disable iff (reset)
        !((|gnt_w) && (|rvalid_w)));

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives both requester ports and models the 256x16 synchronous-read RAM.
// A transaction-level reference model decides, from the arbitration and
// latency rules, which port is granted at which clock edge and what every
// output must read in each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // -------------------------------------------------------------------------
    // RAM model driven by the DUT's command bus
    // -------------------------------------------------------------------------
    logic [15:0] ram_q [256];
    logic [15:0] ram_dout_q;

    always @(posedge clk) begin
        if (bus.mem_cmd == CMD_WRITE) ram_q[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_cmd == CMD_READ)  ram_dout_q <= ram_q[bus.mem_addr];
    end
    assign bus.mem_dout = ram_dout_q;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: one transaction at a time, timed by edge counting
    // -------------------------------------------------------------------------
    int          edge_n      = 0;
    int          next_sample = 0;   // first edge at which a request may be taken
    logic        last_m      = 1'b1;
    logic [1:0]  exp_gnt     = 2'b00;
    logic [1:0]  exp_rv      = 2'b00;
    logic [1:0]  granted     = 2'b00;
    logic [1:0]  exp_cmd     = CMD_NONE;
    logic [7:0]  exp_addr    = 8'h00;
    logic [15:0] exp_din     = 16'h0000;
    logic [15:0] exp_rdata   = 16'h0000;
    logic        rv_pend     = 1'b0;
    logic        rv_port     = 1'b0;
    logic [15:0] rv_data     = 16'h0000;
    logic [15:0] ref_ram [256];

    task automatic model_step();
        logic [1:0]  rq;
        logic [1:0]  wr;
        logic [7:0]  a [2];
        logic [15:0] d [2];
        int          w;
        rq   = {bus.m1_req, bus.m0_req};
        wr   = {bus.m1_write, bus.m0_write};
        a[0] = bus.m0_addr;  a[1] = bus.m1_addr;
        d[0] = bus.m0_wdata; d[1] = bus.m1_wdata;
        exp_gnt = 2'b00;
        exp_rv  = 2'b00;
        granted = 2'b00;
        if (reset) begin
            next_sample = edge_n + 1;
            last_m      = 1'b1;
            rv_pend     = 1'b0;
            exp_cmd     = CMD_NONE;
            exp_addr    = 8'h00;
            exp_din     = 16'h0000;
        end else begin
            exp_cmd = CMD_NONE;
            if (rv_pend) begin
                exp_rv[rv_port] = 1'b1;
                exp_rdata       = rv_data;
                rv_pend         = 1'b0;
            end
            if (edge_n >= next_sample && rq != 2'b00) begin
                if (rq == 2'b11) w = last_m ? 0 : 1;
                else             w = rq[1] ? 1 : 0;
                last_m     = w[0];
                exp_gnt[w] = 1'b1;
                granted[w] = 1'b1;
                exp_addr   = a[w];
                exp_din    = d[w];
                if (wr[w]) begin
                    exp_cmd       = CMD_WRITE;
                    ref_ram[a[w]] = d[w];
                    next_sample   = edge_n + 2;
                end else begin
                    exp_cmd     = CMD_READ;
                    rv_pend     = 1'b1;
                    rv_port     = w[0];
                    rv_data     = ref_ram[a[w]];
                    next_sample = edge_n + 3;
                end
                $display("txn edge=%0d port=%0d %s addr=%02h data=%04h", edge_n, w,
                         wr[w] ? "WR" : "RD", a[w], wr[w] ? d[w] : ref_ram[a[w]]);
            end
        end
        edge_n++;
    endtask

    task automatic run_checks();
        logic [1:0] rv_exp;
        rv_exp = reset ? 2'b00 : exp_rv;
        check_eq("m0_gnt",    32'(bus.m0_gnt),    32'(exp_gnt[0]));
        check_eq("m1_gnt",    32'(bus.m1_gnt),    32'(exp_gnt[1]));
        check_eq("m0_rvalid", 32'(bus.m0_rvalid), 32'(rv_exp[0]));
        check_eq("m1_rvalid", 32'(bus.m1_rvalid), 32'(rv_exp[1]));
        check_eq("mem_cmd",   32'(bus.mem_cmd),   32'(exp_cmd));
        check_eq("mem_addr",  32'(bus.mem_addr),  32'(exp_addr));
        check_eq("mem_din",   32'(bus.mem_din),   32'(exp_din));
        if (rv_exp != 2'b00) check_eq("rdata", 32'(bus.rdata), 32'(exp_rdata));
    endtask

    // One clock: model at the edge, optional reset raised just after it,
    // outputs compared on the falling edge.
    task automatic tick(input bit mid_reset);
        @(posedge clk);
        model_step();
        if (mid_reset) begin
            #1;
            reset = 1'b1;
        end
        @(negedge clk);
        run_checks();
    endtask

    // -------------------------------------------------------------------------
    // Requester drive helpers
    // -------------------------------------------------------------------------
    task automatic set_port(input int p, input logic rq, input logic wr,
                            input logic [7:0] a, input logic [15:0] d);
        if (p == 0) begin
            bus.m0_req = rq; bus.m0_write = wr; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = rq; bus.m1_write = wr; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic set_req(input int p, input logic rq);
        if (p == 0) bus.m0_req = rq;
        else        bus.m1_req = rq;
    endtask

    // Present one request, wait for the model's grant, then drop req.
    // Returns at the falling edge of the gnt cycle.
    task automatic do_req(input int p, input logic wr, input logic [7:0] a,
                          input logic [15:0] d);
        int n;
        set_port(p, 1'b1, wr, a, d);
        n = 0;
        do begin
            tick(1'b0);
            n++;
        end while (!granted[p] && n < 20);
        set_req(p, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int t;
        int tprev;
        int grants;
        logic nxt;
        int k;

        set_port(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_port(1, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Reset: outputs idle, address/data registers cleared.
        reset = 1'b1;
        repeat (3) tick(1'b0);
        reset = 1'b0;
        tick(1'b0);

        // Port 0 writes -23 to word 25.
        do_req(0, 1'b1, 8'h19, 16'hFFE9);
        check_eq("t1_m0_gnt", 32'(bus.m0_gnt), 32'd1);
        check_eq("t1_cmd_wr", 32'(bus.mem_cmd), 32'(CMD_WRITE));
        tick(1'b0);
        check_eq("t1_cmd_none", 32'(bus.mem_cmd), 32'(CMD_NONE));
        check_eq("t1_ram25", 32'(ram_q[25]), 32'h0000_FFE9);

        // Port 1 reads it back.
        do_req(1, 1'b0, 8'h19, 16'h0000);
        check_eq("t2_m1_gnt", 32'(bus.m1_gnt), 32'd1);
        tick(1'b0);
        check_eq("t2_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
        check_eq("t2_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
        check_eq("t2_rdata", 32'(bus.rdata), 32'h0000_FFE9);
        tick(1'b0);

        // Continuous read contention from reset: grants alternate 0,1,0,1.
        do_req(0, 1'b1, 8'h00, 16'hA000);
        tick(1'b0);
        do_req(0, 1'b1, 8'h01, 16'hB001);
        tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        set_port(0, 1'b1, 1'b0, 8'h00, 16'h0000);
        set_port(1, 1'b1, 1'b0, 8'h01, 16'h0000);
        nxt = 1'b0; grants = 0; tprev = 0;
        for (t = 0; t < 30; t++) begin
            tick(1'b0);
            if (bus.m0_gnt || bus.m1_gnt) begin
                check_eq("t3_order", 32'(bus.m1_gnt), 32'(nxt));
                if (grants > 0) check_eq("t3_gap", 32'(t - tprev), 32'd3);
                nxt = ~nxt;
                tprev = t;
                grants++;
            end
        end
        check_eq("t3_count", 32'(grants), 32'd10);
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (3) tick(1'b0);

        // Port 0 holds req for four back-to-back writes to words 0..3.
        set_port(0, 1'b1, 1'b1, 8'h00, 16'hC000);
        k = 0; tprev = 0;
        for (t = 0; t < 20 && k < 4; t++) begin
            tick(1'b0);
            if (bus.m0_gnt) begin
                if (k > 0) check_eq("t4_gap", 32'(t - tprev), 32'd2);
                tprev = t;
            end
            if (granted[0]) begin
                k++;
                if (k < 4) set_port(0, 1'b1, 1'b1, 8'(k), 16'hC000 + 16'(k));
                else       set_req(0, 1'b0);
            end
        end
        repeat (2) tick(1'b0);
        for (int i = 0; i < 4; i++)
            check_eq("t4_ram", 32'(ram_q[i]), 32'h0000_C000 + 32'(i));

        // Reset raised during the RESP cycle of a port-1 read.
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        do_req(1, 1'b0, 8'h19, 16'h0000);
        tick(1'b1);
        check_eq("t5_no_rvalid", 32'(bus.m1_rvalid), 32'd0);
        tick(1'b0);
        reset = 1'b0;
        set_port(0, 1'b1, 1'b1, 8'h40, 16'h1234);
        set_port(1, 1'b1, 1'b1, 8'h41, 16'h5678);
        tick(1'b0);
        check_eq("t5_tie_m0", 32'(bus.m0_gnt), 32'd1);
        check_eq("t5_tie_m1", 32'(bus.m1_gnt), 32'd0);
        set_req(0, 1'b0);
        for (t = 0; t < 6; t++) begin
            tick(1'b0);
            if (granted[1]) set_req(1, 1'b0);
        end

        // Preload the random address window, then random traffic.
        for (int i = 0; i < 16; i++) do_req(0, 1'b1, 8'(i), 16'($urandom));
        repeat (2) tick(1'b0);
        for (int c = 0; c < 2000; c++) begin
            tick(1'b0);
            if (reset) reset = 1'b0;
            else if ($urandom_range(199) == 0) reset = 1'b1;
            for (int p = 0; p < 2; p++) begin
                logic cur_req;
                cur_req = (p == 0) ? bus.m0_req : bus.m1_req;
                if (granted[p]) begin
                    if ($urandom_range(1) == 1)
                        set_port(p, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom));
                    else
                        set_req(p, 1'b0);
                end else if (!cur_req && $urandom_range(3) == 0) begin
                    set_port(p, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom));
                end
            end
        end
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (4) tick(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
